// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads and buffers returned words for the decoder.
// Optional IFETCH_PERF_EN adds perf_fetched/perf_flushed event counters.
module ifetch32 #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] iout,
  output logic [31:0] pc_out,
  output logic        ivalid,
  input  logic        iready,
  input  logic        ib,
  input  logic [31:0] bv,
  input  logic        bl,
  output logic        link_we,
  output logic [31:0] link_val
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop;
  logic [31:0]   fpc, resp_pc;

  logic          pop, branch, grant, rsp, rsp_drop, push;
  logic [CW-1:0] out_next;
  logic [CW:0]   in_use;
  logic [31:0]   target;

  // Handshakes: a request transfers on a cycle with imem_req && imem_gnt; the decoder
  // takes the head on a cycle with ivalid && iready; imem_rvalid has no back-pressure.
  assign pop      = ivalid && iready;
  assign branch   = pop && ib;
  assign grant    = imem_req && imem_gnt;
  assign rsp      = imem_rvalid && (outstanding != '0);
  assign rsp_drop = rsp && (drop != '0);
  assign push     = rsp && !rsp_drop && !branch;
  assign target   = pc_out + 32'd8 + bv;

  // Outstanding requests plus buffered words never exceed the FIFO capacity.
  assign in_use   = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign out_next = outstanding + CW'(grant) - CW'(rsp);

  assign imem_req  = !rst && (in_use < DEPTH_C);
  assign imem_addr = fpc;
  assign ivalid    = (count != '0);
  assign iout      = fifo_data[rd_ptr];
  assign pc_out    = fifo_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      link_we     <= 1'b0;
      link_val    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      outstanding <= out_next;
      link_we     <= branch && bl;
      if (branch && bl) link_val <= pc_out + 32'd4;
      if (branch) begin
        // Every request still in flight after this edge belongs to the old path.
        fpc     <= target;
        resp_pc <= target;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        drop    <= out_next;
      end else begin
        if (grant) fpc <= fpc + 32'd4;
        if (rsp_drop) drop <= drop - 1'b1;
        if (push) begin
          fifo_data[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]   <= resp_pc;
          wr_ptr            <= wr_ptr + 1'b1;
          resp_pc           <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic        rsp_flush;
  logic [31:0] flush_n;

  // On a branch the popped head is consumed, not flushed; a word arriving that cycle is flushed.
  assign rsp_flush = rsp && !rsp_drop && branch;
  assign flush_n   = 32'(rsp_drop) +
                     (branch ? (32'(count) - 32'd1 + 32'(rsp_flush)) : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_flushed <= perf_flushed + flush_n;
    end
  end
`else
  // Without performance counters the fetch datapath is unchanged.
`endif

endmodule
